// File: rtl/operand_streamer_pkg.sv
// operand_streamer_pkg
//   Shared constants for the operand streamer slice: default memory depth,
//   default ALU latency, address/length widths, the 2-bit FSM encoding and
//   a helper that clamps a requested stream length to the memory depth.
package operand_streamer_pkg;

    localparam int DEPTH  = 16;   // entries in operand and result memories
    localparam int LAT    = 1;    // cycles from D to a valid alu_result
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 5;
    localparam int DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_FIN    = 2'd3;

    // Effective stream length: min(len, depth).
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                                 input int depth);
        if (int'(len) > depth) begin
            return LEN_W'(depth);
        end
        return len;
    endfunction

endpackage

// File: rtl/operand_streamer_if.sv
// operand_streamer_if
//   Bundles every non-clock/reset signal of operand_streamer.
//   master : the environment (writes operands, requests streams, supplies
//            alu_result, reads results)
//   slave  : the streamer itself
//   Signals: wr_en/wr_addr/wr_data (operand write port), start/len (stream
//   request), D (operand to ALU), alu_result (ALU return), rd_addr/rd_data
//   (result read port), busy, done, state (FSM state for observation).
//
//   Handshake: start is a request sampled on a rising edge. It is accepted
//   only when busy=0 in IDLE and len!=0; busy acts as the inverted ready, so
//   a start seen while busy (or with len=0) is simply dropped, never queued.
//   Completion is a single-cycle done pulse on the cycle busy is first low.
interface operand_streamer_if;
    import operand_streamer_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] D;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    state_t            state;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, alu_result, rd_addr,
        input  D, rd_data, busy, done, state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, alu_result, rd_addr,
        output D, rd_data, busy, done, state
    );

endinterface

// File: rtl/operand_streamer_regfile.sv
// byte_regfile
//   DEPTH x 8 storage with one write port and one registered read port.
//   Ports:
//     clock, reset_n      : clock and async active-low reset (read register only)
//     we, waddr, wdata    : write port, applied on the rising edge
//     re, rclr, raddr     : read enable, synchronous clear, read address
//     rdata               : registered read data (holds when re=0)
//   Storage is never reset; only the read register is. Addresses wrap
//   modulo DEPTH. WRITE_FIRST selects what a same-edge read of the entry
//   being written returns: the new data (1) or the old contents (0).
module byte_regfile #(
    parameter int DEPTH       = 16,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  we,
    input  logic [operand_streamer_pkg::ADDR_W-1:0] waddr,
    input  logic [7:0]                            wdata,
    input  logic                                  re,
    input  logic                                  rclr,
    input  logic [operand_streamer_pkg::ADDR_W-1:0] raddr,
    output logic [7:0]                            rdata
);
    import operand_streamer_pkg::*;

    logic [7:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a);
        return ADDR_W'(int'(a) % DEPTH);
    endfunction

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wrap(waddr)] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 8'h00;
        end else if (rclr) begin
            rdata <= 8'h00;
        end else if (re) begin
            if (WRITE_FIRST && we && (wrap(waddr) == wrap(raddr))) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[wrap(raddr)];
            end
        end
    end

endmodule

// File: rtl/operand_streamer.sv
// operand_streamer
//   Streams N=min(len,DEPTH) stored operand bytes onto D, one per cycle,
//   and captures the ALU's answers (arriving LAT cycles after each operand)
//   into a result memory that can be read at any time.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     bus (slave)    : operand writes, start/len, D, alu_result,
//                      rd_addr/rd_data, busy, done, state
//   D is the registered read port of the operand memory: the start edge
//   loads mem[0], each STREAM cycle but the last loads the next operand,
//   DRAIN holds the last one, and the DRAIN->FIN edge clears it to 0.
//   Cycle map from the start edge: STREAM 1..N, DRAIN N+1..N+LAT, FIN N+LAT+1.
module operand_streamer #(
    parameter int DEPTH = operand_streamer_pkg::DEPTH,
    parameter int LAT   = operand_streamer_pkg::LAT
) (
    input logic               clock,
    input logic               reset_n,
    operand_streamer_if.slave bus
);
    import operand_streamer_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] idx;       // index of the operand currently on D
    logic [ADDR_W-1:0] cap_idx;   // next result slot to capture into
    logic [LEN_W-1:0]  n_lat;     // latched effective length
    logic [7:0]        dcnt;      // DRAIN cycle counter
    logic              busy_q;
    logic              done_q;
    logic [LAT-1:0]    cap_pipe;  // delays "operand on D" by LAT cycles

    logic              accept;
    logic              last_op;
    logic              drain_end;
    logic              cap_en;
    logic              op_we;
    logic              op_re;
    logic              op_clr;
    logic [ADDR_W-1:0] op_raddr;

    assign accept    = (state == ST_IDLE) && bus.start && (bus.len != '0);
    assign last_op   = (LEN_W'(idx) == (n_lat - LEN_W'(1)));
    assign drain_end = (dcnt == 8'(LAT - 1));
    assign cap_en    = cap_pipe[LAT-1];

    // Operand writes are only accepted while idle; a write on the start
    // edge reaches D through the write-first bypass of the operand memory.
    assign op_we    = bus.wr_en && !busy_q;
    assign op_re    = accept || ((state == ST_STREAM) && !last_op);
    assign op_clr   = (state == ST_DRAIN) && drain_end;
    assign op_raddr = (state == ST_IDLE) ? '0 : idx + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cap_idx  <= '0;
            n_lat    <= '0;
            dcnt     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cap_pipe <= '0;
        end else begin
            done_q      <= 1'b0;
            cap_pipe[0] <= (state == ST_STREAM);
            for (int j = 1; j < LAT; j++) begin
                cap_pipe[j] <= cap_pipe[j-1];
            end
            if (cap_en) begin
                cap_idx <= cap_idx + ADDR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        n_lat   <= eff_len(bus.len, DEPTH);
                        idx     <= '0;
                        cap_idx <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (last_op) begin
                        dcnt  <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    byte_regfile #(.DEPTH(DEPTH), .WRITE_FIRST(1'b1)) u_opmem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (op_we),
        .waddr   (bus.wr_addr),
        .wdata   (bus.wr_data),
        .re      (op_re),
        .rclr    (op_clr),
        .raddr   (op_raddr),
        .rdata   (bus.D)
    );

    // Read-first: a read of the slot being captured returns the old value.
    byte_regfile #(.DEPTH(DEPTH), .WRITE_FIRST(1'b0)) u_resmem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (cap_en),
        .waddr   (cap_idx),
        .wdata   (bus.alu_result),
        .re      (1'b1),
        .rclr    (1'b0),
        .raddr   (bus.rd_addr),
        .rdata   (bus.rd_data)
    );

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state;

endmodule

// File: tb/tb_operand_streamer.sv
// tb_operand_streamer
//   Directed sequence with randomized operand data. A stand-in for the
//   team ALU (one register stage, LAT=1, Q=0 after reset) sits on D /
//   alu_result: it alternates add and subtract of the previous and current
//   D byte while busy, starting with add. Expected results come from a
//   per-operand formula over the stored operands.
module tb_operand_streamer;

    localparam int DEPTH = 16;
    localparam int LAT   = 1;

    logic clock;
    logic reset_n;

    operand_streamer_if sif ();

    operand_streamer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] res_m [DEPTH];
    bit         res_v [DEPTH];

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ALU stand-in
    logic [7:0] alu_q;
    logic [7:0] alu_prev;
    logic       alu_sub;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_q    <= 8'h00;
            alu_prev <= 8'h00;
            alu_sub  <= 1'b0;
        end else begin
            alu_q    <= alu_sub ? (alu_prev - sif.D) : (alu_prev + sif.D);
            alu_prev <= sif.D;
            alu_sub  <= sif.busy ? ~alu_sub : 1'b0;
        end
    end

    assign sif.alu_result = alu_q;

    // driver tasks
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        sif.wr_en   = 1'b1;
        sif.wr_addr = 4'(addr);
        sif.wr_data = data;
        tick();
        sif.wr_en   = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            if (res_v[i]) begin
                sif.rd_addr = 4'(i);
                tick();
                chk($sformatf("res[%0d]", i), sif.rd_data, res_m[i]);
            end
        end
    endtask

    // One complete stream with per-cycle checks of D/busy/done/state.
    //   busy_start_k : cycle in which a start (len=7) is driven while busy
    //   wr_k         : cycle of a write of wr_val to address 0 (0 = start cycle)
    //   probe        : result slot held on rd_addr during the run (-1 = none)
    task automatic run_stream(input int len, input int busy_start_k,
                              input int wr_k, input logic [7:0] wr_val,
                              input int probe);
        int         n;
        logic [7:0] snap [DEPTH];
        logic [7:0] old_probe;
        logic [7:0] exp_d;
        logic [7:0] prev;
        n = (len > DEPTH) ? DEPTH : len;
        sif.start = 1'b1;
        sif.len   = 5'(len);
        if (wr_k == 0) begin
            sif.wr_en   = 1'b1;
            sif.wr_addr = 4'd0;
            sif.wr_data = wr_val;
            mem_m[0]    = wr_val;
        end
        old_probe = 8'h00;
        if (probe >= 0) begin
            sif.rd_addr = 4'(probe);
            old_probe   = res_m[probe];
        end
        for (int i = 0; i < DEPTH; i++) snap[i] = mem_m[i];
        tick();
        sif.start = 1'b0;
        sif.len   = 5'd0;
        sif.wr_en = 1'b0;
        for (int k = 1; k <= n + LAT + 1; k++) begin
            if (k <= n)            exp_d = snap[k-1];
            else if (k <= n + LAT) exp_d = snap[n-1];
            else                   exp_d = 8'h00;
            chk($sformatf("D c%0d", k), sif.D, exp_d);
            chk($sformatf("busy c%0d", k), 8'(sif.busy), 8'(k <= n + LAT));
            chk($sformatf("done c%0d", k), 8'(sif.done), 8'(k == n + LAT + 1));
            chk($sformatf("state c%0d", k), 8'(sif.state),
                (k <= n) ? 8'd1 : ((k <= n + LAT) ? 8'd2 : 8'd3));
            if (probe >= 0 && k == probe + 2 + LAT) begin
                chk("probe old", sif.rd_data, old_probe);
            end
            if (k == busy_start_k) begin
                sif.start = 1'b1;
                sif.len   = 5'd7;
            end
            if (k == wr_k) begin
                sif.wr_en   = 1'b1;
                sif.wr_addr = 4'd0;
                sif.wr_data = wr_val;
            end
            tick();
            sif.start = 1'b0;
            sif.len   = 5'd0;
            sif.wr_en = 1'b0;
        end
        // result i = prev + op for even i, prev - op for odd i (prev of op 0 is 0)
        for (int i = 0; i < n; i++) begin
            prev     = (i == 0) ? 8'h00 : snap[i-1];
            res_m[i] = (i % 2 == 0) ? prev + snap[i] : prev - snap[i];
            res_v[i] = 1'b1;
        end
        chk("post state", 8'(sif.state), 8'd0);
        chk("post busy", 8'(sif.busy), 8'd0);
        chk("post done", 8'(sif.done), 8'd0);
        chk("post D", sif.D, 8'h00);
        if (probe >= 0) begin
            chk("probe new", sif.rd_data, res_m[probe]);
        end
    endtask

    // directed sequence
    initial begin
        reset_n     = 1'b0;
        sif.wr_en   = 1'b0;
        sif.wr_addr = 4'd0;
        sif.wr_data = 8'h00;
        sif.start   = 1'b0;
        sif.len     = 5'd0;
        sif.rd_addr = 4'd0;
        for (int i = 0; i < DEPTH; i++) res_v[i] = 1'b0;
        tick();
        tick();
        chk("rst D", sif.D, 8'h00);
        chk("rst busy", 8'(sif.busy), 8'd0);
        chk("rst done", 8'(sif.done), 8'd0);
        chk("rst rd_data", sif.rd_data, 8'h00);
        chk("rst state", 8'(sif.state), 8'd0);
        reset_n = 1'b1;
        tick();

        // basic three-operand stream
        wr(0, 8'd5);
        wr(1, 8'd3);
        wr(2, 8'd9);
        for (int i = 3; i < DEPTH; i++) wr(i, 8'($urandom_range(0, 255)));
        run_stream(3, -1, -1, 8'h00, -1);
        read_all();

        // len=0 start is ignored
        sif.start = 1'b1;
        sif.len   = 5'd0;
        tick();
        sif.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("len0 state", 8'(sif.state), 8'd0);
            chk("len0 busy", 8'(sif.busy), 8'd0);
            chk("len0 done", 8'(sif.done), 8'd0);
            tick();
        end

        // over-long request clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom_range(0, 255)));
        run_stream(20, -1, -1, 8'h00, -1);
        read_all();

        // start and write while busy are both dropped
        wr(0, 8'h5C);
        run_stream(4, 2, 3, 8'hAA, -1);
        run_stream(2, -1, -1, 8'h00, -1);

        // write-first on the start edge, and same-edge read of res[2]
        wr(1, 8'($urandom_range(0, 255)));
        wr(2, mem_m[2] + 8'd1);
        run_stream(3, -1, 0, 8'($urandom_range(0, 255)), 2);
        read_all();

        // reset in stream cycle 2, then an immediate restart
        for (int i = 0; i < 3; i++) wr(i, 8'($urandom_range(0, 255)));
        sif.start = 1'b1;
        sif.len   = 5'd3;
        tick();
        sif.start = 1'b0;
        sif.len   = 5'd0;
        chk("abort c1 D", sif.D, mem_m[0]);
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort D", sif.D, 8'h00);
        chk("abort busy", 8'(sif.busy), 8'd0);
        chk("abort done", 8'(sif.done), 8'd0);
        chk("abort state", 8'(sif.state), 8'd0);
        chk("abort rd_data", sif.rd_data, 8'h00);
        tick();
        chk("abort done hold", 8'(sif.done), 8'd0);
        reset_n = 1'b1;
        run_stream(3, -1, -1, 8'h00, -1);
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
